// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard and forwarding control for the 5-stage MIPS core. Keeps its own
//   E/M/W pipeline of writer tags built from the decoder's D-stage tags.
//   It compares those tags against the operand needs (Tuse) of the
//   instruction in D. From that it produces the D-stage stall and the
//   operand-mux selects for the D, E and M stages. All outputs are
//   combinational from the current tags.
//
//   Optional build macro: FWD_W_EN
//     Defined   : the W stage is a forwarding source
//                 (fwd1D/fwd2D = 3, fwd1E/fwd2E = 2, fwd2M = 1).
//     Undefined : the register file is write-first. W is never selected and
//                 fwd2M is always 0.
//
// Ports
//   clk              clock, rising edge
//   rst              synchronous reset, active-high
//   ra1D, ra2D       D-stage rs / rt register addresses
//   tuse1D, tuse2D   cycles until rs / rt is consumed (3 = not used)
//   waD              D-stage destination register
//   resD             D-stage result type (RES_*)
//   DEMWclr          flush of every tracked stage (exception / eret)
//   stall            hold PC and F/D, insert a bubble into E
//   fwd1D, fwd2D     D operand select: 0 RF, 1 E (PC+8), 2 M, 3 W
//   fwd1E, fwd2E     E operand select: 0 pipe reg, 1 M, 2 W
//   fwd2M            M store-data select: 0 pipe reg, 1 W
module hazard_fwd_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] ra1D,
   input  logic [4:0] ra2D,
   input  logic [1:0] tuse1D,
   input  logic [1:0] tuse2D,
   input  logic [4:0] waD,
   input  logic [2:0] resD,
   input  logic       DEMWclr,
   output logic       stall,
   output logic [1:0] fwd1D,
   output logic [1:0] fwd2D,
   output logic [1:0] fwd1E,
   output logic [1:0] fwd2E,
   output logic       fwd2M
);

   localparam logic [2:0] RES_NW  = 3'd0;
   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;
   localparam logic [2:0] RES_PC  = 3'd3;
   localparam logic [2:0] RES_MD  = 3'd4;

`ifdef FWD_W_EN
   localparam logic W_FWD = 1'b1;
`else
   localparam logic W_FWD = 1'b0;
`endif

   // Cycles until the result exists, counted at E entry.
   function automatic logic [1:0] tnew_of(input logic [2:0] res);
      case (res)
         RES_ALU: tnew_of = 2'd1;
         RES_MD:  tnew_of = 2'd1;
         RES_DM:  tnew_of = 2'd2;
         default: tnew_of = 2'd0;   // RES_PC is ready at E, RES_NW writes nothing
      endcase
   endfunction

   function automatic logic [1:0] dec_sat(input logic [1:0] t);
      dec_sat = (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // Tag pipeline. Only fields that are read later are kept. M needs rt for
   // store data. W needs only wa/res, because its tnew is always 0.
   logic [4:0] e_ra1_reg, e_ra2_reg, e_wa_reg;
   logic [2:0] e_res_reg;
   logic [1:0] e_tnew_reg;
   logic [4:0] m_ra2_reg, m_wa_reg;
   logic [2:0] m_res_reg;
   logic [1:0] m_tnew_reg;
   logic [4:0] w_wa_reg;
   logic [2:0] w_res_reg;

   always_ff @(posedge clk) begin
      if (rst || DEMWclr) begin
         e_ra1_reg  <= '0;
         e_ra2_reg  <= '0;
         e_wa_reg   <= '0;
         e_res_reg  <= RES_NW;
         e_tnew_reg <= '0;
         m_ra2_reg  <= '0;
         m_wa_reg   <= '0;
         m_res_reg  <= RES_NW;
         m_tnew_reg <= '0;
         w_wa_reg   <= '0;
         w_res_reg  <= RES_NW;
      end else begin
         if (stall) begin
            e_ra1_reg  <= '0;
            e_ra2_reg  <= '0;
            e_wa_reg   <= '0;
            e_res_reg  <= RES_NW;
            e_tnew_reg <= '0;
         end else begin
            e_ra1_reg  <= ra1D;
            e_ra2_reg  <= ra2D;
            e_wa_reg   <= waD;
            e_res_reg  <= resD;
            e_tnew_reg <= tnew_of(resD);
         end
         m_ra2_reg  <= e_ra2_reg;
         m_wa_reg   <= e_wa_reg;
         m_res_reg  <= e_res_reg;
         m_tnew_reg <= dec_sat(e_tnew_reg);
         w_wa_reg   <= m_wa_reg;
         w_res_reg  <= m_res_reg;
      end
   end

   // A stage holds a real writer only if it writes a register other than $0.
   logic vld_e, vld_m, vld_w;
   assign vld_e = (e_res_reg != RES_NW) && (e_wa_reg != 5'd0);
   assign vld_m = (m_res_reg != RES_NW) && (m_wa_reg != 5'd0);
   assign vld_w = (w_res_reg != RES_NW) && (w_wa_reg != 5'd0);

   // ---------------- D-stage sources (rs, rt) ----------------
   logic [4:0] d_ra   [2];
   logic [1:0] d_tuse [2];
   logic [1:0] d_fwd  [2];
   logic [1:0] d_stall;

   assign d_ra[0]   = ra1D;
   assign d_ra[1]   = ra2D;
   assign d_tuse[0] = tuse1D;
   assign d_tuse[1] = tuse2D;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dsrc
         logic       hit_e, hit_m, hit_w;
         logic [1:0] near_tnew;
         logic [1:0] fsel;

         assign hit_e = (d_ra[gi] != 5'd0) && vld_e && (e_wa_reg == d_ra[gi]);
         assign hit_m = (d_ra[gi] != 5'd0) && vld_m && (m_wa_reg == d_ra[gi]);
         assign hit_w = (d_ra[gi] != 5'd0) && vld_w && (w_wa_reg == d_ra[gi]);

         // Only the youngest matching writer counts. Once it has matched, an
         // older stage is never consulted, even if that older stage is ready.
         always_comb begin
            near_tnew = 2'd0;
            fsel      = 2'd0;
            if (hit_e) begin
               near_tnew = e_tnew_reg;
               if (e_tnew_reg == 2'd0 && e_res_reg == RES_PC)
                  fsel = 2'd1;
            end else if (hit_m) begin
               near_tnew = m_tnew_reg;
               if (m_tnew_reg == 2'd0)
                  fsel = 2'd2;
            end else if (hit_w && W_FWD) begin
               fsel = 2'd3;
            end
         end

         assign d_fwd[gi]   = fsel;
         assign d_stall[gi] = (d_tuse[gi] != 2'd3) && (d_tuse[gi] < near_tnew);
      end
   endgenerate

   assign stall = |d_stall;
   assign fwd1D = d_fwd[0];
   assign fwd2D = d_fwd[1];

   // ---------------- E-stage sources (rs, rt of the E tag) ----------------
   logic [4:0] e_ra  [2];
   logic [1:0] e_fwd [2];

   assign e_ra[0] = e_ra1_reg;
   assign e_ra[1] = e_ra2_reg;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_esrc
         logic hit_m, hit_w;
         assign hit_m = (e_ra[gi] != 5'd0) && vld_m && (m_wa_reg == e_ra[gi]);
         assign hit_w = (e_ra[gi] != 5'd0) && vld_w && (w_wa_reg == e_ra[gi]);
         // A matching M writer that is not ready yet (load) shadows W.
         assign e_fwd[gi] = hit_m ? ((m_tnew_reg == 2'd0) ? 2'd1 : 2'd0)
                          : (hit_w && W_FWD) ? 2'd2 : 2'd0;
      end
   endgenerate

   assign fwd1E = e_fwd[0];
   assign fwd2E = e_fwd[1];

   // ---------------- M-stage store data ----------------
   assign fwd2M = W_FWD && (m_ra2_reg != 5'd0) && vld_w && (w_wa_reg == m_ra2_reg);

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

   localparam logic [2:0] RES_NW  = 3'd0;
   localparam logic [2:0] RES_ALU = 3'd1;
   localparam logic [2:0] RES_DM  = 3'd2;
   localparam logic [2:0] RES_PC  = 3'd3;
   localparam logic [2:0] RES_MD  = 3'd4;

`ifdef FWD_W_EN
   localparam int W_ON = 1;
`else
   localparam int W_ON = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ra1D, ra2D, waD;
   logic [1:0] tuse1D, tuse2D;
   logic [2:0] resD;
   logic       DEMWclr;
   logic       stall;
   logic [1:0] fwd1D, fwd2D, fwd1E, fwd2E;
   logic       fwd2M;

   always #5 clk = ~clk;

   hazard_fwd_unit dut (
      .clk     (clk),
      .rst     (rst),
      .ra1D    (ra1D),
      .ra2D    (ra2D),
      .tuse1D  (tuse1D),
      .tuse2D  (tuse2D),
      .waD     (waD),
      .resD    (resD),
      .DEMWclr (DEMWclr),
      .stall   (stall),
      .fwd1D   (fwd1D),
      .fwd2D   (fwd2D),
      .fwd1E   (fwd1E),
      .fwd2E   (fwd2E),
      .fwd2M   (fwd2M)
   );

   // Reference model: in-flight instructions by age (0 = E, 1 = M, 2 = W).
   // Each entry keeps its Tnew at E entry. The remaining Tnew is derived from age.
   typedef struct {
      logic [4:0] ra1;
      logic [4:0] ra2;
      logic [4:0] wa;
      logic [2:0] res;
      int         t0;
   } instr_t;

   typedef struct {
      int stall;
      int f1d, f2d, f1e, f2e, f2m;
   } out_t;

   instr_t pipe [3];
   out_t   exp_q [$];
   int     n_cmp = 0;
   int     n_bad = 0;
   int     n_txn = 0;
   int     obs_stall, obs_f1d, obs_f2d, obs_f1e, obs_f2e, obs_f2m;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int tnew_init(input logic [2:0] r);
      if (r == RES_DM) return 2;
      if (r == RES_ALU || r == RES_MD) return 1;
      return 0;
   endfunction

   function automatic int tnew_at(input int t0, input int age);
      return (t0 > age) ? t0 - age : 0;
   endfunction

   function automatic bit writes(input instr_t x, input logic [4:0] r);
      return (r != 5'd0) && (x.res != RES_NW) && (x.wa == r);
   endfunction

   function automatic void d_eval(input logic [4:0] ra, input logic [1:0] tuse,
                                  output int st, output int f);
      int k = -1;
      int t;
      st = 0;
      f  = 0;
      for (int j = 0; j < 3; j++)
         if (k < 0 && writes(pipe[j], ra)) k = j;
      if (k < 0) return;
      t = tnew_at(pipe[k].t0, k);
      if (tuse != 2'd3 && int'(tuse) < t) st = 1;
      if (k == 0)      f = (t == 0 && pipe[0].res == RES_PC) ? 1 : 0;
      else if (k == 1) f = (t == 0) ? 2 : 0;
      else             f = W_ON ? 3 : 0;
   endfunction

   function automatic int e_eval(input logic [4:0] ra);
      if (writes(pipe[1], ra)) return (tnew_at(pipe[1].t0, 1) == 0) ? 1 : 0;
      if (writes(pipe[2], ra)) return W_ON ? 2 : 0;
      return 0;
   endfunction

   function automatic out_t model_out(input logic [4:0] a1, input logic [4:0] a2,
                                      input logic [1:0] u1, input logic [1:0] u2);
      out_t o;
      int s1, s2;
      d_eval(a1, u1, s1, o.f1d);
      d_eval(a2, u2, s2, o.f2d);
      o.stall = s1 | s2;
      o.f1e = e_eval(pipe[0].ra1);
      o.f2e = e_eval(pipe[0].ra2);
      o.f2m = writes(pipe[2], pipe[1].ra2) ? W_ON : 0;
      return o;
   endfunction

   task automatic model_clear();
      for (int j = 0; j < 3; j++) pipe[j] = '{ra1: 0, ra2: 0, wa: 0, res: RES_NW, t0: 0};
   endtask

   // One transaction: drive the D-stage tags, queue the expected outputs,
   // compare at the falling edge, then let the model follow the rising edge.
   task automatic step(input bit r, input bit c,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic [1:0] u1, input logic [1:0] u2,
                       input logic [4:0] w, input logic [2:0] rs);
      out_t e, got;
      rst = r; DEMWclr = c;
      ra1D = a1; ra2D = a2; tuse1D = u1; tuse2D = u2; waD = w; resD = rs;
      e = model_out(a1, a2, u1, u2);
      exp_q.push_back(e);
      @(negedge clk);
      got = exp_q.pop_front();
      obs_stall = int'(stall);
      obs_f1d = int'(fwd1D); obs_f2d = int'(fwd2D);
      obs_f1e = int'(fwd1E); obs_f2e = int'(fwd2E);
      obs_f2m = int'(fwd2M);
      check_eq("stall", obs_stall, got.stall);
      check_eq("fwd1D", obs_f1d, got.f1d);
      check_eq("fwd2D", obs_f2d, got.f2d);
      check_eq("fwd1E", obs_f1e, got.f1e);
      check_eq("fwd2E", obs_f2e, got.f2e);
      check_eq("fwd2M", obs_f2m, got.f2m);
      $display("txn %0d rst=%0d clr=%0d ra1=%0d ra2=%0d tu=%0d/%0d wa=%0d res=%0d -> stall=%0d f1D=%0d f2D=%0d f1E=%0d f2E=%0d f2M=%0d",
               n_txn, r, c, a1, a2, u1, u2, w, rs,
               obs_stall, obs_f1d, obs_f2d, obs_f1e, obs_f2e, obs_f2m);
      n_txn++;
      @(posedge clk);
      if (r || c) begin
         model_clear();
      end else begin
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (e.stall != 0) pipe[0] = '{ra1: 0, ra2: 0, wa: 0, res: RES_NW, t0: 0};
         else              pipe[0] = '{ra1: a1, ra2: a2, wa: w, res: rs, t0: tnew_init(rs)};
      end
      #1;
   endtask

   task automatic nop();
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, RES_NW);
   endtask

   task automatic drain();
      repeat (3) nop();
   endtask

   initial begin
      model_clear();

      // Reset state: colliding inputs must not produce hazards.
      step(1'b1, 1'b0, 5'd5, 5'd5, 2'd0, 2'd0, 5'd5, RES_ALU);
      check_eq("rst_stall", obs_stall, 0);
      step(1'b1, 1'b0, 5'd5, 5'd5, 2'd0, 2'd0, 5'd5, RES_DM);
      check_eq("rst_fwd1D", obs_f1d, 0);

      drain();
      // lw $8 ; addu rs=$8 (tuse 1): stall once, then W forward at E
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, RES_DM);
      step(1'b0, 1'b0, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, RES_ALU);
      check_eq("lw_use_stall", obs_stall, 1);
      step(1'b0, 1'b0, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, RES_ALU);
      check_eq("lw_use_release", obs_stall, 0);
      nop();
      check_eq("lw_use_fwd1E", obs_f1e, W_ON ? 2 : 0);

      drain();
      // addu $9 ; beq rs=$9 (tuse 0): stall once, then M forward at D
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, RES_ALU);
      step(1'b0, 1'b0, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, RES_NW);
      check_eq("beq_stall", obs_stall, 1);
      step(1'b0, 1'b0, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, RES_NW);
      check_eq("beq_fwd1D", obs_f1d, 2);

      drain();
      // jal ; jr $31: PC+8 forwarded from E, no stall
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd31, RES_PC);
      step(1'b0, 1'b0, 5'd31, 5'd0, 2'd0, 2'd3, 5'd0, RES_NW);
      check_eq("jr_stall", obs_stall, 0);
      check_eq("jr_fwd1D", obs_f1d, 1);

      drain();
      // lw $10 ; sw rt=$10 (tuse 2): no stall, store data from W at M
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, RES_DM);
      step(1'b0, 1'b0, 5'd0, 5'd10, 2'd3, 2'd2, 5'd0, RES_NW);
      check_eq("sw_stall", obs_stall, 0);
      nop();
      check_eq("sw_fwd2E", obs_f2e, 0);
      nop();
      check_eq("sw_fwd2M", obs_f2m, W_ON);

      drain();
      // Writes to $0 never hazard
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, RES_ALU);
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, RES_NW);
      check_eq("r0_stall", obs_stall, 0);
      check_eq("r0_fwd1D", obs_f1d, 0);
      // Flush in the same cycle as a stall clears all tags
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, RES_DM);
      step(1'b0, 1'b1, 5'd8, 5'd0, 2'd1, 2'd3, 5'd9, RES_ALU);
      check_eq("clr_stall_seen", obs_stall, 1);
      step(1'b0, 1'b0, 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, RES_NW);
      check_eq("clr_after_stall", obs_stall, 0);
      check_eq("clr_after_fwd2D", obs_f2d, 0);

      drain();
      // Two writers of $5: the nearest (E, not ready) wins over a ready M
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, RES_ALU);
      step(1'b0, 1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, RES_ALU);
      step(1'b0, 1'b0, 5'd5, 5'd0, 2'd1, 2'd3, 5'd6, RES_ALU);
      check_eq("near_stall", obs_stall, 0);
      check_eq("near_fwd1D", obs_f1d, 0);
      nop();
      check_eq("near_fwd1E", obs_f1e, 1);

      // Random traffic over a small register set so matches are frequent
      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 3'($urandom_range(0, 4)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
